// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the
// instruction-fetch requester (read-only) and the data requester (load/store).
// Data wins arbitration, but only MAX_DM_STREAK times in a row while a fetch
// is waiting, so a fetch can never be starved indefinitely. Every access that
// reaches the memory port is registered, and each one completes with a
// single-cycle valid pulse. A watchdog aborts any access the memory leaves
// hanging.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int TIMEOUT       = 255,
  parameter int TO_W          = 8,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch requester
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  output logic              if_stall_o,
  // data requester
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_valid_o,
  output logic              dm_stall_o,
  // external memory port
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  // sticky watchdog flag
  output logic              err_o
);

  localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IF_BUSY,
    S_DM_BUSY,
    S_RESP
  } state_t;

  state_t              r_state;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;
  logic                r_if_valid;
  logic                r_dm_valid;
  logic                r_err;
  logic [STREAK_W-1:0] r_streak;
  logic [TO_W-1:0]     r_to_cnt;

  logic                w_dm_grant;
  logic [STREAK_W-1:0] w_streak_inc;
  logic [TO_W-1:0]     w_to_next;
  logic                w_timeout;

  // The data requester wins unless a fetch is waiting and data has already
  // been granted MAX_DM_STREAK times in a row.
  assign w_dm_grant   = dm_req_i &
                        (~if_req_i | (r_streak < STREAK_W'(MAX_DM_STREAK)));
  assign w_streak_inc = (r_streak == STREAK_W'(MAX_DM_STREAK)) ?
                        r_streak : r_streak + STREAK_W'(1);
  assign w_to_next    = r_to_cnt + TO_W'(1);
  assign w_timeout    = (w_to_next == TO_W'(TIMEOUT));

  // Stalls are combinational so that a requester is released in the same
  // cycle its valid pulse appears.
  assign if_stall_o  = if_req_i & ~r_if_valid;
  assign dm_stall_o  = dm_req_i & ~r_dm_valid;

  assign if_rdata_o  = r_if_rdata;
  assign if_valid_o  = r_if_valid;
  assign dm_rdata_o  = r_dm_rdata;
  assign dm_valid_o  = r_dm_valid;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign err_o       = r_err;

  // Arbitration FSM. Every output it drives is a register, including the
  // memory request and the valid pulses.
  // NOTE: all state is assigned with <= so every register in this block sees
  // the pre-edge values of the others, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_dm_valid  <= 1'b0;
      r_err       <= 1'b0;
      r_streak    <= '0;
      r_to_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dm_grant) begin
            r_state     <= S_DM_BUSY;
            r_mem_req   <= 1'b1;
            r_mem_we    <= dm_we_i;
            r_mem_addr  <= dm_addr_i;
            r_mem_wdata <= dm_wdata_i;
            // The streak counts only data grants that leave a fetch waiting.
            r_streak    <= if_req_i ? w_streak_inc : '0;
          end else if (if_req_i) begin
            r_state    <= S_IF_BUSY;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= if_addr_i;
            r_streak   <= '0;
          end else begin
            r_streak <= '0;
          end
        end

        S_IF_BUSY, S_DM_BUSY: begin
          if (mem_ready_i || w_timeout) begin
            // Completion or abort: an aborted access returns zero data.
            r_mem_req <= 1'b0;
            r_state   <= S_RESP;
            if (r_state == S_IF_BUSY) begin
              r_if_valid <= 1'b1;
              r_if_rdata <= mem_ready_i ? mem_rdata_i : '0;
            end else begin
              r_dm_valid <= 1'b1;
              r_dm_rdata <= mem_ready_i ? mem_rdata_i : '0;
            end
            if (!mem_ready_i) begin
              r_err    <= 1'b1;
              r_to_cnt <= w_to_next;
            end
          end else begin
            r_to_cnt <= w_to_next;
          end
        end

        S_RESP: begin
          // Valid pulse is visible this cycle; no grant is made here.
          r_if_valid <= 1'b0;
          r_dm_valid <= 1'b0;
          r_to_cnt   <= '0;
          r_state    <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
